// File: rtl/sm_hex_pager.sv
// Paged hex debug display: snapshot/hold, debounced page key, leading-zero blanking, parallel + scanned segments.
// Latency: data->hexSeg 2 cycles, hexSeg->scanSeg 1 cycle, accepted key press->page 1 cycle.
// Backpressure: none; the display path is free-running and samples data every cycle unless hold is high.
module sm_hex_pager #(
    parameter int DATA_WIDTH      = 32,
    parameter int DIGITS          = 6,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCAN_DIV        = 4,
    localparam int NIBBLES = (DATA_WIDTH + 3) / 4,
    localparam int PAGES   = (NIBBLES + DIGITS - 1) / DIGITS,
    localparam int PAGE_W  = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  hold,
    input  logic                  pageKey,
    input  logic                  blankLz,
    output logic [DIGITS*7-1:0]   hexSeg,
    output logic [6:0]            scanSeg,
    output logic [DIGITS-1:0]     scanSel,
    output logic [PAGE_W-1:0]     page
);
    localparam int EXT_W = PAGES * DIGITS * 4;
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = $clog2((SCAN_DIV > 1) ? SCAN_DIV : 2);
    localparam int IDX_W = $clog2((DIGITS > 1) ? DIGITS : 2);

    logic [DATA_WIDTH-1:0] snap;
    logic [EXT_W-1:0]      snap_ext;
    logic                  key_meta, key_sync, key_db, key_db_q, key_press;
    logic [DB_W-1:0]       db_cnt;
    logic [DIV_W-1:0]      div;
    logic [IDX_W-1:0]      idx;
    logic [DIGITS*7-1:0]   hex_nxt;
    int                    msn;
    int                    n;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     snap <= '0;
        else if (!hold) snap <= data;
    end

    // Debounce counts samples that disagree with the accepted level; one agreeing sample restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
            key_db   <= 1'b1;
            key_db_q <= 1'b1;
            db_cnt   <= '0;
        end else begin
            key_meta <= pageKey;
            key_sync <= key_meta;
            key_db_q <= key_db;
            if (key_sync == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                key_db <= key_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign key_press = key_db_q & ~key_db;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         page <= '0;
        else if (key_press) page <= (page == PAGE_W'(PAGES - 1)) ? '0 : page + 1'b1;
    end

    assign snap_ext = EXT_W'(snap);

    always_comb begin
        msn = 0;
        for (int i = 0; i < NIBBLES; i++)
            if (snap_ext[i*4 +: 4] != 4'h0) msn = i;
    end

    // Blanking is judged against the whole word, so pages above the top nonzero nibble go dark.
    always_comb begin
        hex_nxt = '1;
        n       = 0;
        for (int d = 0; d < DIGITS; d++) begin
            n = int'(page) * DIGITS + d;
            if (n < NIBBLES && !(blankLz && n > msn))
                hex_nxt[d*7 +: 7] = seg7(snap_ext[n*4 +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hexSeg <= '1;
        else        hexSeg <= hex_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div     <= '0;
            idx     <= '0;
            scanSel <= '1;
            scanSeg <= 7'h7F;
        end else begin
            scanSel <= ~(DIGITS'(1) << idx);
            scanSeg <= hexSeg[int'(idx)*7 +: 7];
            if (div == DIV_W'(SCAN_DIV - 1)) begin
                div <= '0;
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                div <= div + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sm_hex_pager.sv
// Directed + randomized bench for sm_hex_pager with a value-level display model.
module tb_sm_hex_pager;
    localparam int DB = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data;
    logic        hold;
    logic        pageKey;
    logic        blankLz;
    logic [41:0] hexSeg;
    logic [6:0]  scanSeg;
    logic [5:0]  scanSel;
    logic [0:0]  page;

    int total = 0;
    int bad   = 0;
    int exp_page = 0;
    logic [6:0]  seg_tab [16];
    logic [41:0] prev_hex;
    logic [5:0]  exp_sel;
    int          exp_idx;
    logic [31:0] rv;
    bit          rb;

    sm_hex_pager #(.DATA_WIDTH(32), .DIGITS(6), .DEBOUNCE_CYCLES(DB), .SCAN_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .hold(hold), .pageKey(pageKey),
        .blankLz(blankLz), .hexSeg(hexSeg), .scanSeg(scanSeg), .scanSel(scanSel), .page(page)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Display model: count significant hex digits of the value, then pick/blank each digit.
    function automatic logic [41:0] model_hex(input logic [31:0] v, input int pg, input bit blz);
        logic [41:0] r;
        logic [31:0] t;
        int sig, top, nib;
        t = v;
        sig = 0;
        while (t != 0) begin
            t = t >> 4;
            sig++;
        end
        top = (sig == 0) ? 0 : sig - 1;
        for (int d = 0; d < 6; d++) begin
            nib = pg * 6 + d;
            if (nib >= 8 || (blz && nib > top)) r[7*d +: 7] = 7'h7F;
            else r[7*d +: 7] = seg_tab[4'((v >> (4 * nib)) & 32'hF)];
        end
        return r;
    endfunction

    task automatic press();
        pageKey = 1'b0;
        repeat (DB + 2) step();
        pageKey = 1'b1;
        repeat (DB + 8) step();
        exp_page = (exp_page + 1) % 2;
    endtask

    task automatic show(input string tag, input logic [31:0] v, input bit blz);
        data = v;
        blankLz = blz;
        repeat (2) step();
        chk(tag, 64'(hexSeg), 64'(model_hex(v, exp_page, blz)));
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst_n = 1'b0; data = '0; hold = 1'b0; pageKey = 1'b1; blankLz = 1'b0;
        repeat (3) step();
        chk("rst_hex", 64'(hexSeg), 64'({42{1'b1}}));
        chk("rst_sel", 64'(scanSel), 64'h3F);
        chk("rst_seg", 64'(scanSeg), 64'h7F);
        chk("rst_page", 64'(page), 64'h0);
        rst_n = 1'b1;

        show("pg0_12345678", 32'h12345678, 1'b0);
        chk("pg0_digit0", 64'(hexSeg[6:0]), 64'h00);
        press();
        chk("press1_page", 64'(page), 64'(exp_page));
        chk("pg1_12345678", 64'(hexSeg), 64'(model_hex(32'h12345678, exp_page, 1'b0)));
        press();
        chk("wrap_page", 64'(page), 64'(exp_page));
        chk("wrap_hex", 64'(hexSeg), 64'(model_hex(32'h12345678, exp_page, 1'b0)));

        for (int g = 0; g < 5; g++) begin
            pageKey = 1'b0;
            repeat (DB - 1) step();
            pageKey = 1'b1;
            repeat (4) step();
        end
        repeat (20) step();
        chk("glitch_page", 64'(page), 64'(exp_page));
        press();
        chk("long_press_page", 64'(page), 64'(exp_page));
        repeat (30) step();
        chk("release_page", 64'(page), 64'(exp_page));

        for (int i = 0; i < 12; i++) begin
            rv = $urandom >> $urandom_range(0, 31);
            rb = 1'($urandom_range(0, 1));
            show("rand_pg1", rv, rb);
        end
        press();
        chk("back_pg0", 64'(page), 64'(exp_page));

        show("lz_A05", 32'h00000A05, 1'b1);
        show("lz_zero", 32'h0, 1'b1);
        chk("lz_zero_d0", 64'(hexSeg[6:0]), 64'h40);
        for (int i = 0; i < 20; i++) begin
            rv = $urandom >> $urandom_range(0, 31);
            rb = 1'($urandom_range(0, 1));
            show("rand_pg0", rv, rb);
        end

        show("blz_off", 32'h00000A05, 1'b0);
        blankLz = 1'b1;
        step();
        chk("blz_toggle", 64'(hexSeg), 64'(model_hex(32'h00000A05, exp_page, 1'b1)));

        show("hold_pre", 32'hDEADBEEF, 1'b0);
        hold = 1'b1;
        data = 32'h0;
        repeat (3) step();
        chk("hold_frozen", 64'(hexSeg), 64'(model_hex(32'hDEADBEEF, exp_page, 1'b0)));
        hold = 1'b0;
        repeat (2) step();
        chk("hold_release_d0", 64'(hexSeg[6:0]), 64'h40);

        data = 32'h12345678;
        blankLz = 1'b0;
        pageKey = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_hex", 64'(hexSeg), 64'({42{1'b1}}));
        chk("midrst_sel", 64'(scanSel), 64'h3F);
        chk("midrst_seg", 64'(scanSeg), 64'h7F);
        chk("midrst_page", 64'(page), 64'h0);
        exp_page = 0;
        step();
        rst_n = 1'b1;
        prev_hex = hexSeg;
        for (int k = 1; k <= 28; k++) begin
            step();
            exp_idx = ((k - 1) / 4) % 6;
            exp_sel = 6'h3F ^ (6'd1 << exp_idx);
            chk("scan_sel", 64'(scanSel), 64'(exp_sel));
            chk("scan_seg", 64'(scanSeg), 64'(prev_hex[7*exp_idx +: 7]));
            prev_hex = hexSeg;
        end
        pageKey = 1'b1;
        repeat (40) step();
        exp_page = 1;
        chk("held_key_one_press", 64'(page), 64'(exp_page));
        chk("held_key_hex", 64'(hexSeg), 64'(model_hex(32'h12345678, exp_page, 1'b0)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
